// File: rtl/hello_scroll_seq.sv
// Message sequencer: holds five character codes and steps a 0..4 select at a prescaled rate.
// Optional blink blanking is enabled by defining HELLO_SCROLL_BLINK_EN.
module hello_scroll_seq #(
  parameter int         DIV   = 4,
  parameter logic [2:0] CODE0 = 3'd0,
  parameter logic [2:0] CODE1 = 3'd1,
  parameter logic [2:0] CODE2 = 3'd2,
  parameter logic [2:0] CODE3 = 3'd2,
  parameter logic [2:0] CODE4 = 3'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] wr_data,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic [2:0] u,
  output logic [2:0] v,
  output logic [2:0] w,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       wrap,
  output logic       blank
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          step_prev_q, step_prev_d;
  logic [2:0]    sel_q, sel_d;
  logic          wrap_q, wrap_d;
  logic [2:0]    slot_q [5];
  logic [2:0]    slot_d [5];
  logic          tick, advance;

  always_comb begin
    tick        = run && (pre_q == PW'(DIV - 1));
    pre_d       = (run && !tick) ? pre_q + PW'(1) : '0;
    step_prev_d = step;
    // Step edges only count while paused; the prescaler owns the select while running.
    advance     = run ? tick : (step && !step_prev_q);
    sel_d       = sel_q;
    wrap_d      = 1'b0;
    if (advance) begin
      if (dir) begin
        sel_d  = (sel_q == 3'd0) ? 3'd4 : sel_q - 3'd1;
        wrap_d = (sel_q == 3'd0);
      end else begin
        sel_d  = (sel_q >= 3'd4) ? 3'd0 : sel_q + 3'd1;
        wrap_d = (sel_q >= 3'd4);
      end
    end
    for (int i = 0; i < 5; i++) begin
      slot_d[i] = slot_q[i];
      if (wr_en && (wr_addr == 3'(i))) slot_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      step_prev_q <= 1'b0;
      sel_q       <= 3'd0;
      wrap_q      <= 1'b0;
      slot_q[0]   <= CODE0;
      slot_q[1]   <= CODE1;
      slot_q[2]   <= CODE2;
      slot_q[3]   <= CODE3;
      slot_q[4]   <= CODE4;
    end else begin
      pre_q       <= pre_d;
      step_prev_q <= step_prev_d;
      sel_q       <= sel_d;
      wrap_q      <= wrap_d;
      for (int i = 0; i < 5; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign {s2, s1, s0} = sel_q;
  assign wrap         = wrap_q;

`ifdef HELLO_SCROLL_BLINK_EN
  logic blank_q, blank_d;

  always_comb blank_d = blank_q ^ wrap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= 1'b0;
    else        blank_q <= blank_d;
  end

  // Blanking only masks the view; stored slots keep taking writes.
  assign blank = blank_q;
  assign u     = blank_q ? 3'd7 : slot_q[0];
  assign v     = blank_q ? 3'd7 : slot_q[1];
  assign w     = blank_q ? 3'd7 : slot_q[2];
  assign x     = blank_q ? 3'd7 : slot_q[3];
  assign y     = blank_q ? 3'd7 : slot_q[4];
`else
  assign blank = 1'b0;
  assign u     = slot_q[0];
  assign v     = slot_q[1];
  assign w     = slot_q[2];
  assign x     = slot_q[3];
  assign y     = slot_q[4];
`endif

endmodule

// File: tb/tb_hello_scroll_seq.sv
// Bench for hello_scroll_seq: directed table, hand sequences, and random stimulus vs a reference model.
module tb_hello_scroll_seq;

  localparam int DIV = 4;
`ifdef HELLO_SCROLL_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, run, dir, step, wr_en;
  logic [2:0] wr_addr, wr_data;
  logic       s2, s1, s0, wrap, blank;
  logic [2:0] u, v, w, x, y;

  hello_scroll_seq #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .s2(s2), .s1(s1), .s0(s0), .u(u), .v(v), .w(w), .x(x), .y(y),
    .wrap(wrap), .blank(blank)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: select as an integer mod 5, prescaler as run-length of consecutive run cycles.
  int m_sel;
  int m_slot [5];
  int m_run_len;
  bit m_step_prev;
  bit m_wrap;
  bit m_blank;

  function automatic void m_reset();
    m_sel       = 0;
    m_slot      = '{0, 1, 2, 2, 3};
    m_run_len   = 0;
    m_step_prev = 1'b0;
    m_wrap      = 1'b0;
    m_blank     = 1'b0;
  endfunction

  function automatic void m_clock();
    bit adv;
    int prev;
    prev = m_sel;
    if (run) begin
      m_run_len++;
      adv = (m_run_len % DIV) == 0;
    end else begin
      m_run_len = 0;
      adv = step && !m_step_prev;
    end
    m_step_prev = step;
    m_wrap = 1'b0;
    if (adv) begin
      m_sel  = dir ? (m_sel + 4) % 5 : (m_sel + 1) % 5;
      m_wrap = dir ? (prev == 0) : (prev == 4);
    end
    if (wr_en && wr_addr < 3'd5) m_slot[wr_addr] = int'(wr_data);
    if (BLINK && m_wrap) m_blank = !m_blank;
  endfunction

  function automatic logic [2:0] m_disp(int i);
    return (BLINK && m_blank) ? 3'd7 : 3'(m_slot[i]);
  endfunction

  function automatic logic [19:0] m_vec();
    return {3'(m_sel), m_disp(0), m_disp(1), m_disp(2), m_disp(3), m_disp(4), m_wrap, m_blank};
  endfunction

  function automatic logic [19:0] act_vec();
    return {s2, s1, s0, u, v, w, x, y, wrap, blank};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    m_clock();
    @(negedge clk);
    check("model", 32'(act_vec()), 32'(m_vec()));
  endtask

  task automatic drive(input bit r, input bit d, input bit st, input bit we,
                       input logic [2:0] a, input logic [2:0] dat);
    run = r; dir = d; step = st; wr_en = we; wr_addr = a; wr_data = dat;
  endtask

  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, 32'(act_vec()), 32'({3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 1'b0, 1'b0}));
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         run, dir, step, we;
    logic [2:0] addr, data;
    int         sel;
    bit         wrap;
    int         u_exp, w_exp;
    bit         blk;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int changes, wraps, last_sel;

    tbl[0]  = '{0, 0, 1, 0, 3'd0, 3'd0, 1, 0, 0, 2, 0};
    tbl[1]  = '{0, 0, 1, 0, 3'd0, 3'd0, 1, 0, 0, 2, 0};
    tbl[2]  = '{0, 0, 0, 0, 3'd0, 3'd0, 1, 0, 0, 2, 0};
    tbl[3]  = '{0, 1, 1, 0, 3'd0, 3'd0, 0, 0, 0, 2, 0};
    tbl[4]  = '{0, 1, 0, 0, 3'd0, 3'd0, 0, 0, 0, 2, 0};
    tbl[5]  = '{0, 1, 1, 0, 3'd0, 3'd0, 4, 1, 0, 2, 1};
    tbl[6]  = '{0, 0, 0, 0, 3'd0, 3'd0, 4, 0, 0, 2, 1};
    tbl[7]  = '{0, 0, 1, 0, 3'd0, 3'd0, 0, 1, 0, 2, 0};
    tbl[8]  = '{0, 0, 0, 1, 3'd2, 3'd5, 0, 0, 0, 5, 0};
    tbl[9]  = '{0, 0, 0, 1, 3'd6, 3'd1, 0, 0, 0, 5, 0};
    tbl[10] = '{1, 0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 5, 0};
    tbl[11] = '{1, 0, 1, 0, 3'd0, 3'd0, 0, 0, 0, 5, 0};
    tbl[12] = '{1, 0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 5, 0};
    tbl[13] = '{1, 0, 0, 1, 3'd0, 3'd6, 1, 0, 6, 5, 0};

    drive(0, 0, 0, 0, 3'd0, 3'd0);
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_state", 32'(act_vec()), 32'(m_vec()));

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].run, tbl[i].dir, tbl[i].step, tbl[i].we, tbl[i].addr, tbl[i].data);
      tick_cycle();
      check($sformatf("tbl%0d", i),
            32'({s2, s1, s0, u, w, wrap, blank}),
            32'({3'(tbl[i].sel),
                 (BLINK && tbl[i].blk) ? 3'd7 : 3'(tbl[i].u_exp),
                 (BLINK && tbl[i].blk) ? 3'd7 : 3'(tbl[i].w_exp),
                 tbl[i].wrap, BLINK && tbl[i].blk}));
    end

    // Reset in the middle of a run must restore the default message without a clock edge.
    drive(1, 0, 0, 0, 3'd0, 3'd0);
    async_reset("reset_mid_run");

    // Auto-scroll up from reset: five ticks in 20 cycles, exactly one wrap.
    changes = 0; wraps = 0; last_sel = 0;
    drive(1, 0, 0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 20; i++) begin
      tick_cycle();
      if (int'({s2, s1, s0}) != last_sel) changes++;
      last_sel = int'({s2, s1, s0});
      if (wrap) wraps++;
    end
    check("scroll_up_changes", 32'(changes), 32'd5);
    check("scroll_up_wraps", 32'(wraps), 32'd1);
    check("scroll_up_sel", 32'(last_sel), 32'd0);

    // Step held high while paused advances exactly once.
    drive(0, 0, 0, 0, 3'd0, 3'd0);
    tick_cycle();
    changes = 0; last_sel = int'({s2, s1, s0});
    drive(0, 0, 1, 0, 3'd0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      tick_cycle();
      if (int'({s2, s1, s0}) != last_sel) changes++;
      last_sel = int'({s2, s1, s0});
    end
    check("step_hold_once", 32'(changes), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) run = ~run;
      dir     = 1'($urandom_range(0, 1));
      step    = 1'($urandom_range(0, 1));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) async_reset("reset_random");
      tick_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hello_scroll_seq.md
Name: hello_scroll_seq

Overview:
- Upstream sequencer for the five-character 7-segment message stage.
- Holds five 3-bit character codes and drives them on u, v, w, x, y.
- Drives the select lines s2, s1, s0, stepping 0..4 at a prescaled rate so the downstream 5:1 mux and decoders cycle through the message.
- Supports run/pause, single-step, scroll direction, and runtime rewrite of any message slot.

Parameters:
- DIV, 4, prescaler period in clk cycles per scroll tick; legal range >= 2. Silicon builds override with the board clock rate.
- CODE0, 3'd0, reset code of slot 0 (H).
- CODE1, 3'd1, reset code of slot 1 (E).
- CODE2, 3'd2, reset code of slot 2 (L).
- CODE3, 3'd2, reset code of slot 3 (L).
- CODE4, 3'd3, reset code of slot 4 (O).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = auto-scroll on prescaler tick; 0 = paused.
- dir  in  1  0 = select counts up; 1 = select counts down.
- step  in  1  single-step request, level input; rising edge detected internally.
- wr_en  in  1  slot write strobe.
- wr_addr  in  3  slot index 0..4.
- wr_data  in  3  new character code.
- s2, s1, s0  out  1 each  select code {s2,s1,s0}, always in 0..4.
- u, v, w, x, y  out  3 each  slot 0..4 character codes.
- wrap  out  1  one-cycle pulse when select wraps.
- blank  out  1  blink blanking request; see Optional Feature.

Behaviour:
- Reset (async assert, sync release):
  - {s2,s1,s0}=0; u..y=CODE0..CODE4.
  - wrap=0; blank=0; prescaler=0; step edge register=0.
- All outputs are registered; no combinational path from any input to any output.
- Prescaler:
  - When run=1, counts 0..DIV-1 and wraps to 0.
  - tick is an internal one-cycle pulse in the cycle the count equals DIV-1.
  - When run=0, the count is held at 0, so the first tick after resuming comes DIV cycles after run rises.
- Advance sources:
  - run=1: advance on tick.
  - run=0: advance when step_prev=0 and step=1.
  - A step edge while run=1 is ignored.
- Advance updates the select on the next clk edge:
  - dir=0: 0→1→2→3→4→0.
  - dir=1: 0→4→3→2→1→0.
  - dir is sampled in the advance cycle; changing dir mid-count has no other effect.
- wrap is high for exactly the cycle after a 4→0 (dir=0) or 0→4 (dir=1) transition; otherwise 0.
- Slot write:
  - wr_en=1 with wr_addr 0..4 loads wr_data into that slot; the output updates on the next edge.
  - wr_addr 5..7 is ignored with no state change.
  - A write coinciding with an advance applies both; they are independent.
- Select value is never outside 0..4.
- Reset mid-scroll immediately restores all reset values, including the default message.

Optional Feature:
- Macro: HELLO_SCROLL_BLINK_EN.
- Defined:
  - blank toggles on every wrap event.
  - While blank=1, u..y all read 3'd7 (decoder blank code).
  - Stored slots are unchanged; writes still land.
  - Reset clears blank to 0.
- Undefined:
  - blank is tied 0 and u..y always show the stored slots.
  - No extra flops are synthesised.

Test Plan:
- Reset check: rst_n low mid-run → select=0, u..y=0,1,2,2,3, wrap=0, blank=0, with no clk edge needed.
- Auto-scroll up: DIV=4, run=1, dir=0 for 20 cycles → select 0,1,2,3,4,0 changing every 4 cycles; wrap pulses once, 1 cycle after 4→0.
- Auto-scroll down: dir=1 from select=0 → next tick gives 4 with wrap=1 for one cycle, then 3, 2.
- Pause and step: run=0, hold step high 10 cycles → select advances exactly once; a step edge while run=1 → no extra advance.
- Slot write: wr_addr=2, wr_data=5 → w=5 next cycle; wr_addr=6, wr_data=1 → no slot changes; a write in a tick cycle → both the write and the advance occur.
- Blink (macro defined): two wraps → u..y read 7 between the first and second wrap and stored codes after; macro undefined → blank stays 0 throughout.
